// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared types for the scalar register-file writeback path.
//   regbits_t : architectural register index
//   word_t    : register data word
//   arb_req_t : writeback requester identity, used for round-robin state
//   wb_beat_t : one writeback beat (destination + data)
package rf_writeback_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } arb_req_t;

    typedef struct packed {
        regbits_t sel;
        word_t    data;
    } wb_beat_t;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback bus between the two producers (ALU, load return) and the
// register-file write port.
//   alu_* / mem_* : valid/ready request channels, one per producer
//   rf_*          : registered write-port drive toward the register file
// master = producer/register-file side, slave = arbiter.
interface rf_writeback_arbiter_if;
    import rf_writeback_arbiter_pkg::*;

    logic     alu_wvalid;
    regbits_t alu_wsel;
    word_t    alu_wdata;
    logic     alu_wready;

    logic     mem_wvalid;
    regbits_t mem_wsel;
    word_t    mem_wdata;
    logic     mem_wready;

    logic     rf_wen;
    regbits_t rf_wsel;
    word_t    rf_wdata;

    modport master (
        output alu_wvalid, alu_wsel, alu_wdata,
        input  alu_wready,
        output mem_wvalid, mem_wsel, mem_wdata,
        input  mem_wready,
        input  rf_wen, rf_wsel, rf_wdata
    );

    modport slave (
        input  alu_wvalid, alu_wsel, alu_wdata,
        output alu_wready,
        input  mem_wvalid, mem_wsel, mem_wdata,
        output mem_wready,
        output rf_wen, rf_wsel, rf_wdata
    );

endinterface

// File: rtl/rf_writeback_arbiter_scoreboard.sv
// rf_scoreboard: one pending-write bit per architectural register.
//   CLK, nRST          : clock, async active-low reset
//   flush              : synchronous clear of every busy bit
//   set_en / set_sel   : new producer issued for set_sel (r0 never set)
//   clr_en / clr_sel   : register file written this edge
//   busy               : scoreboard vector
//   chk_sel1/2         : sources under check
//   hazard1/2          : source has a write still pending
module rf_scoreboard
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter bit HAZARD_R0 = 1'b0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             set_en,
    input  regbits_t         set_sel,
    input  logic             clr_en,
    input  regbits_t         clr_sel,
    output logic [NREGS-1:0] busy,
    input  regbits_t         chk_sel1,
    input  regbits_t         chk_sel2,
    output logic             hazard1,
    output logic             hazard2
);

    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    // One-hot decode; r0 is never tracked since it is never a real producer.
    assign w_set = (set_en && (set_sel != '0)) ? (ONE << set_sel) : '0;
    assign w_clr = clr_en ? (ONE << clr_sel) : '0;

    // Set is OR-ed after the clear so a same-edge re-issue keeps the bit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign busy    = r_busy;
    assign hazard1 = r_busy[chk_sel1] & ((chk_sel1 != '0) | HAZARD_R0);
    assign hazard2 = r_busy[chk_sel2] & ((chk_sel2 != '0) | HAZARD_R0);

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin arbitration of ALU and load-return
// writebacks onto the single register-file write port, a one-cycle
// registered write stage, and the RAW-hazard scoreboard.
//   CLK, nRST            : clock, async active-low reset
//   bus (slave)          : producer request channels and rf write drive
//   issue_en / issue_sel : destination of a newly issued instruction
//   flush                : clears scoreboard and pending write beat
//   chk_sel1/2, hazard1/2: RAW hazard query for the issue stage
//   busy                 : scoreboard vector
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter bit HAZARD_R0 = 1'b0
) (
    input  logic                   CLK,
    input  logic                   nRST,
    rf_writeback_arbiter_if.slave  bus,
    input  logic                   issue_en,
    input  regbits_t               issue_sel,
    input  logic                   flush,
    input  regbits_t               chk_sel1,
    input  regbits_t               chk_sel2,
    output logic                   hazard1,
    output logic                   hazard2,
    output logic [NREGS-1:0]       busy
);

    arb_req_t r_last_grant;
    logic     w_gnt_alu;
    logic     w_gnt_mem;
    logic     w_gnt;
    wb_beat_t w_beat;

    logic     r_wen;
    regbits_t r_wsel;
    word_t    r_wdata;

    // ALU wins when alone or when MEM had the last grant; MEM takes the rest.
    always_comb begin
        w_gnt_alu = bus.alu_wvalid & (~bus.mem_wvalid | (r_last_grant == REQ_MEM));
        w_gnt_mem = bus.mem_wvalid & ~w_gnt_alu;
        w_gnt     = w_gnt_alu | w_gnt_mem;
        w_beat    = w_gnt_alu ? '{sel: bus.alu_wsel, data: bus.alu_wdata}
                              : '{sel: bus.mem_wsel, data: bus.mem_wdata};
    end

    assign bus.alu_wready = w_gnt_alu;
    assign bus.mem_wready = w_gnt_mem;

    // Flush leaves the round-robin pointer where it was.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_last_grant <= REQ_MEM;
        end else if (w_gnt && !flush) begin
            r_last_grant <= w_gnt_alu ? REQ_ALU : REQ_MEM;
        end
    end

    // Write stage: a granted r0 beat is accepted but never written.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wen   <= 1'b0;
            r_wsel  <= '0;
            r_wdata <= '0;
        end else if (flush) begin
            r_wen   <= 1'b0;
        end else if (w_gnt) begin
            r_wen   <= (w_beat.sel != '0);
            r_wsel  <= w_beat.sel;
            r_wdata <= w_beat.data;
        end else begin
            r_wen   <= 1'b0;
        end
    end

    assign bus.rf_wen   = r_wen;
    assign bus.rf_wsel  = r_wsel;
    assign bus.rf_wdata = r_wdata;

    // Busy clears on the same edge the register file captures the data.
    rf_scoreboard #(
        .NREGS     (NREGS),
        .HAZARD_R0 (HAZARD_R0)
    ) u_scoreboard (
        .CLK      (CLK),
        .nRST     (nRST),
        .flush    (flush),
        .set_en   (issue_en),
        .set_sel  (issue_sel),
        .clr_en   (r_wen),
        .clr_sel  (r_wsel),
        .busy     (busy),
        .chk_sel1 (chk_sel1),
        .chk_sel2 (chk_sel2),
        .hazard1  (hazard1),
        .hazard2  (hazard2)
    );

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
    import rf_writeback_arbiter_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        issue_en;
    regbits_t    issue_sel;
    logic        flush;
    regbits_t    chk_sel1;
    regbits_t    chk_sel2;
    logic        hazard1;
    logic        hazard2;
    logic [31:0] busy;

    rf_writeback_arbiter_if bus();

    rf_writeback_arbiter #(.NREGS(32), .HAZARD_R0(1'b0)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .issue_en  (issue_en),
        .issue_sel (issue_sel),
        .flush     (flush),
        .chk_sel1  (chk_sel1),
        .chk_sel2  (chk_sel2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int ntests = 0;
    int nfail  = 0;
    wb_beat_t exp_q[$];
    wb_beat_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic wb_beat_t mk(input regbits_t s, input word_t d);
        wb_beat_t b;
        b.sel  = s;
        b.data = d;
        return b;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_wvalid = 1'b0; bus.alu_wsel = '0; bus.alu_wdata = '0;
        bus.mem_wvalid = 1'b0; bus.mem_wsel = '0; bus.mem_wdata = '0;
        issue_en = 1'b0; issue_sel = '0; flush = 1'b0;
        chk_sel1 = '0; chk_sel2 = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        tick();
        nRST = 1'b1;
    endtask

    // Monitor: every write the register file sees must match the next expected beat.
    always @(negedge CLK) begin
        if (nRST && bus.rf_wen) begin
            if (exp_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL rf_write_unexpected: got sel=%0d data=%h, required no write",
                         bus.rf_wsel, bus.rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rf_wsel", 64'(bus.rf_wsel), 64'(mon_e.sel));
                chk("rf_wdata", 64'(bus.rf_wdata), 64'(mon_e.data));
            end
        end
    end

    initial begin
        do_reset();
        // Reset state
        chk("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
        chk("rst_rf_wsel", 64'(bus.rf_wsel), 64'd0);
        chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_wready", 64'(bus.alu_wready), 64'd0);
        chk("rst_mem_wready", 64'(bus.mem_wready), 64'd0);
        chk("rst_hazard1", 64'(hazard1), 64'd0);

        // ALU-only write
        bus.alu_wvalid = 1'b1; bus.alu_wsel = 5'd5; bus.alu_wdata = 32'hDEADBEEF;
        exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
        @(negedge CLK);
        chk("alu_only_ready", 64'(bus.alu_wready), 64'd1);
        chk("alu_only_mem_ready", 64'(bus.mem_wready), 64'd0);
        tick();
        bus.alu_wvalid = 1'b0;
        @(negedge CLK);
        chk("alu_only_rf_wen", 64'(bus.rf_wen), 64'd1);
        tick();
        @(negedge CLK);
        chk("alu_only_rf_wen_drop", 64'(bus.rf_wen), 64'd0);

        // Contention from reset: ALU, then MEM (ALU still valid), then ALU
        do_reset();
        bus.alu_wvalid = 1'b1; bus.alu_wsel = 5'd1; bus.alu_wdata = 32'hA1A1A1A1;
        bus.mem_wvalid = 1'b1; bus.mem_wsel = 5'd2; bus.mem_wdata = 32'hB2B2B2B2;
        exp_q.push_back(mk(5'd1, 32'hA1A1A1A1));
        @(negedge CLK);
        chk("rr1_alu_ready", 64'(bus.alu_wready), 64'd1);
        chk("rr1_mem_ready", 64'(bus.mem_wready), 64'd0);
        tick();
        bus.alu_wsel = 5'd3; bus.alu_wdata = 32'hA3A3A3A3;
        exp_q.push_back(mk(5'd2, 32'hB2B2B2B2));
        @(negedge CLK);
        chk("rr2_alu_ready", 64'(bus.alu_wready), 64'd0);
        chk("rr2_mem_ready", 64'(bus.mem_wready), 64'd1);
        tick();
        bus.mem_wvalid = 1'b0;
        exp_q.push_back(mk(5'd3, 32'hA3A3A3A3));
        @(negedge CLK);
        chk("rr3_alu_ready", 64'(bus.alu_wready), 64'd1);
        tick();
        bus.alu_wvalid = 1'b0;
        @(negedge CLK);
        tick();

        // Hazard on r7 through a MEM write
        chk_sel1 = 5'd7; issue_en = 1'b1; issue_sel = 5'd7;
        @(negedge CLK);
        chk("hz7_before_issue", 64'(hazard1), 64'd0);
        tick();
        issue_en = 1'b0;
        @(negedge CLK);
        chk("hz7_after_issue", 64'(hazard1), 64'd1);
        chk("busy7_set", 64'(busy[7]), 64'd1);
        tick();
        bus.mem_wvalid = 1'b1; bus.mem_wsel = 5'd7; bus.mem_wdata = 32'h00000077;
        exp_q.push_back(mk(5'd7, 32'h00000077));
        @(negedge CLK);
        chk("hz7_mem_ready", 64'(bus.mem_wready), 64'd1);
        chk("hz7_handshake", 64'(hazard1), 64'd1);
        tick();
        bus.mem_wvalid = 1'b0;
        @(negedge CLK);
        chk("hz7_rf_wen_cycle", 64'(hazard1), 64'd1);
        tick();
        @(negedge CLK);
        chk("hz7_cleared", 64'(hazard1), 64'd0);
        chk("busy7_clear", 64'(busy[7]), 64'd0);
        tick();

        // Same-edge set and clear on r9: set wins
        chk_sel2 = 5'd9; issue_en = 1'b1; issue_sel = 5'd9;
        bus.alu_wvalid = 1'b1; bus.alu_wsel = 5'd9; bus.alu_wdata = 32'h00000099;
        exp_q.push_back(mk(5'd9, 32'h00000099));
        @(negedge CLK);
        chk("r9_alu_ready", 64'(bus.alu_wready), 64'd1);
        tick();
        bus.alu_wvalid = 1'b0;
        @(negedge CLK);
        chk("r9_busy_pre", 64'(busy[9]), 64'd1);
        tick();
        issue_en = 1'b0;
        @(negedge CLK);
        chk("r9_set_wins", 64'(busy[9]), 64'd1);
        chk("r9_hazard2", 64'(hazard2), 64'd1);
        tick();
        bus.alu_wvalid = 1'b1; bus.alu_wsel = 5'd9; bus.alu_wdata = 32'h0000009A;
        exp_q.push_back(mk(5'd9, 32'h0000009A));
        @(negedge CLK);
        chk("r9b_alu_ready", 64'(bus.alu_wready), 64'd1);
        tick();
        bus.alu_wvalid = 1'b0;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        chk("r9_busy_cleared", 64'(busy[9]), 64'd0);
        chk("r9_hazard2_cleared", 64'(hazard2), 64'd0);
        tick();

        // r0 writes are handshaked but never performed; r0 never busy
        chk_sel1 = 5'd0;
        bus.alu_wvalid = 1'b1; bus.alu_wsel = 5'd0; bus.alu_wdata = 32'h00001234;
        issue_en = 1'b1; issue_sel = 5'd0;
        @(negedge CLK);
        chk("r0_alu_ready", 64'(bus.alu_wready), 64'd1);
        tick();
        bus.alu_wvalid = 1'b0; issue_en = 1'b0;
        @(negedge CLK);
        chk("r0_rf_wen", 64'(bus.rf_wen), 64'd0);
        chk("r0_busy", 64'(busy), 64'd0);
        chk("r0_hazard1", 64'(hazard1), 64'd0);
        tick();

        // Flush with a granted request
        issue_en = 1'b1; issue_sel = 5'd3;
        tick();
        issue_sel = 5'd4;
        tick();
        issue_en = 1'b0;
        @(negedge CLK);
        chk("flush_busy_pre", 64'(busy), 64'h18);
        tick();
        flush = 1'b1;
        bus.alu_wvalid = 1'b1; bus.alu_wsel = 5'd10; bus.alu_wdata = 32'h000000AA;
        @(negedge CLK);
        chk("flush_alu_ready", 64'(bus.alu_wready), 64'd1);
        tick();
        flush = 1'b0; bus.alu_wvalid = 1'b0;
        @(negedge CLK);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_rf_wen", 64'(bus.rf_wen), 64'd0);
        tick();

        // Reset in the middle of a write-stage beat
        bus.alu_wvalid = 1'b1; bus.alu_wsel = 5'd11; bus.alu_wdata = 32'h000000BB;
        @(negedge CLK);
        chk("mid_rst_alu_ready", 64'(bus.alu_wready), 64'd1);
        tick();
        bus.alu_wvalid = 1'b0;
        chk("mid_rst_rf_wen_live", 64'(bus.rf_wen), 64'd1);
        #1 nRST = 1'b0;
        #1;
        chk("mid_rst_rf_wen", 64'(bus.rf_wen), 64'd0);
        chk("mid_rst_rf_wsel", 64'(bus.rf_wsel), 64'd0);
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_rf_wen", 64'(bus.rf_wen), 64'd0);
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the single write port of the scalar register file between two writeback sources: the ALU/execute stage and the memory load-return path.
- Uses a valid/ready handshake and round-robin priority, and drives a registered write stage onto the rf modport inputs.
- Holds a per-register pending-write scoreboard. Issue logic uses it to detect RAW hazards on rsel1/rsel2 before reading the register file.

Parameters:
- NREGS, 32, number of architectural registers. Must equal 2**width(regbits_t).
- HAZARD_R0, 0, when 0, register 0 never reports busy or hazard.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- alu_wvalid  input  1  ALU writeback request
- alu_wsel  input  regbits_t  ALU destination register
- alu_wdata  input  word_t  ALU result
- alu_wready  output  1  ALU request granted this cycle
- mem_wvalid  input  1  load-return writeback request
- mem_wsel  input  regbits_t  load destination register
- mem_wdata  input  word_t  load data
- mem_wready  output  1  load request granted this cycle
- issue_en  input  1  instruction issued with a destination register
- issue_sel  input  regbits_t  destination of the issued instruction
- flush  input  1  synchronous clear of scoreboard and pending write stage
- chk_sel1  input  regbits_t  source 1 under hazard check
- chk_sel2  input  regbits_t  source 2 under hazard check
- hazard1  output  1  chk_sel1 has a write pending
- hazard2  output  1  chk_sel2 has a write pending
- busy  output  NREGS  scoreboard vector
- rf_wen  output  1  register file write enable
- rf_wsel  output  regbits_t  register file write select
- rf_wdata  output  word_t  register file write data

Behaviour:
- Reset (nRST=0, asynchronous): rf_wen=0, rf_wsel=0, rf_wdata=0, busy=0, last_grant=REQ_MEM, so the ALU wins the first contest. The ready outputs and hazards are combinational and evaluate to 0 while busy=0 and no request is valid.
- Grant logic (combinational):
  - Only one valid request: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Exactly one ready is high per granted cycle. The ready is never high without the matching valid.
- The requester must hold valid/wsel/wdata stable until it sees ready. A transfer completes in the cycle where valid and ready are both high.
- last_grant updates at every edge where a grant occurs.
- Write stage: on the edge after a grant, rf_wen=1 and rf_wsel/rf_wdata take the granted values. If there is no grant, rf_wen=0 and rf_wsel/rf_wdata hold their previous values.
- Latency is exactly one cycle from handshake to rf_wen, and the register file captures the data at the following edge.
- A request with wsel=0 is handshaked normally, but rf_wen stays 0 for that beat.
- The register file never backpressures, so some request is granted every cycle any valid is high. Maximum throughput is 1 write/cycle. Under continuous contention the grants alternate ALU, MEM, ALU, ...
- Scoreboard, evaluated per register r at each edge:
  - Clear when rf_wen=1 and rf_wsel=r.
  - Set when issue_en=1 and issue_sel=r and r!=0.
  - Set and clear together on the same r: set wins, because a new producer was issued.
  - A write to a non-busy register is still performed, and busy is unchanged.
  - issue_en to a register that is already busy leaves it busy. No counting is done; in-order writeback per register is guaranteed by the pipeline.
- Hazards (combinational): hazardN = busy[chk_selN] & (chk_selN!=0 | HAZARD_R0). Because busy clears on the same edge the register file writes, a register reads as non-hazard only once its data is architecturally visible. No bypass is provided.
- flush=1 at an edge: busy=0, rf_wen=0, last_grant is unchanged. Requests granted in the flush cycle are dropped, although their ready was high.
- If reset is asserted mid-transfer, the in-flight write-stage beat is lost and rf_wen drops immediately.

Decomposition:
- cpu_types_pkg gains the enum arb_req_t {REQ_ALU, REQ_MEM}. The module reuses the existing regbits_t and word_t.
- Sub-module rf_scoreboard (CLK, nRST, flush, set_en/set_sel, clr_en/clr_sel, busy, chk_sel1/2, hazard1/2). It is instantiated once; the top level keeps the arbiter and the write stage.

Test Plan:
- Reset then ALU-only request, alu_wsel=5, alu_wdata=32'hDEADBEEF -> alu_wready=1 the same cycle. Next cycle rf_wen=1, rf_wsel=5, rf_wdata=DEADBEEF. The cycle after, rf_wen=0.
- Both valid for 4 cycles (alu_wsel=1, mem_wsel=2), each side dropping valid after its ready -> grants ALU, MEM. rf_wsel sequence 1 then 2 on consecutive cycles.
- issue_en with issue_sel=7, then chk_sel1=7 -> hazard1=1 and busy[7]=1. A MEM write to 7 is handshaked; hazard1 stays 1 through the rf_wen cycle and reads 0 the cycle after.
- Same edge: issue_en/issue_sel=9 while rf_wen=1/rf_wsel=9 -> busy[9]=1 afterwards.
- alu_wsel=0 with alu_wvalid=1 -> alu_wready=1 and rf_wen stays 0. issue_sel=0 -> busy stays 0.
- Set busy[3] and busy[4], assert flush with a request granted -> busy=0 and rf_wen=0 next cycle. nRST pulsed low mid-write -> rf_wen=0 immediately.
